// File: rtl/hv_dac_pkg.sv
// Shared constants, control-word patterns and FSM states for the HV DAC responder.
// ctr_word is {mode, sync_n, start, en}.
package hv_dac_pkg;

  localparam int HV_DAC_W = 16;

  localparam logic [3:0] CTR_IDLE  = 4'hd;
  localparam logic [3:0] CTR_WR_ST = 4'hb;
  localparam logic [3:0] CTR_WR_SH = 4'h9;
  localparam logic [3:0] CTR_RD_ST = 4'h3;
  localparam logic [3:0] CTR_RD_SH = 4'h1;
  localparam logic [3:0] CTR_UPD   = 4'hc;

  localparam int CTR_MODE   = 3;
  localparam int CTR_SYNC_N = 2;
  localparam int CTR_START  = 1;
  localparam int CTR_EN     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_UPD,
    ST_ABORT
  } hv_dac_state_e;

  function automatic logic ctr_legal(input logic [3:0] w);
    case (w)
      CTR_IDLE, CTR_WR_ST, CTR_WR_SH,
      CTR_RD_ST, CTR_RD_SH, CTR_UPD: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // Shift cycles keep sync low and enable high without a start; mode picks write/read.
  function automatic logic ctr_is_shift(input logic [3:0] w);
    return w[CTR_EN] && !w[CTR_SYNC_N] && !w[CTR_START];
  endfunction

endpackage

// File: rtl/hv_dac_rx_shift.sv
// MSB-first serial receive register with a 5-bit bit counter, so a 17th bit is
// distinguishable from a complete 16-bit frame.
module hv_dac_rx_shift
  import hv_dac_pkg::*;
#(
  parameter int WIDTH = HV_DAC_W
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic [4:0]       bit_cnt,
  output logic             full16,
  output logic             over
);

  // clr together with shift restarts the frame with its first bit already captured.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      data    <= shift ? {{(WIDTH-1){1'b0}}, sdi} : '0;
      bit_cnt <= shift ? 5'd1 : 5'd0;
    end else if (shift) begin
      data <= {data[WIDTH-2:0], sdi};
      if (bit_cnt != 5'h1f) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  assign full16 = (bit_cnt == 5'(WIDTH));
  assign over   = (bit_cnt >  5'(WIDTH));

endmodule

// File: rtl/hv_dac_responder.sv
// Far-end responder on the HV DAC ctr_word bus: captures write frames, checks
// readback frames against the stored code and applies the code on update.
module hv_dac_responder
  import hv_dac_pkg::*;
#(
  parameter int WIDTH   = HV_DAC_W,
  parameter int UPD_MIN = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [3:0]       ctr_word,
  input  logic             sdi,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] dac_out,
  output logic             upd_pulse,
  output logic             dac_err,
  output logic [2:0]       rd_cnt,
  output logic             frame_err,
  output logic             upd_err
);

  hv_dac_state_e state, state_nxt;

  logic [WIDTH-1:0] sh_data;
  logic [WIDTH-1:0] rd_word;
  logic [4:0]       bit_cnt;
  logic             full16;
  logic             over;
  logic [2:0]       upd_cnt;

  logic sh_clr, sh_shift;
  logic fe_set, ue_set;
  logic wr_accept, rd_done;
  logic upd_start, upd_inc;
  logic wr_shift, rd_shift;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  hv_dac_rx_shift #(.WIDTH(WIDTH)) u_rx (
    .CLK     (CLK),
    .reset   (reset),
    .clr     (sh_clr),
    .shift   (sh_shift),
    .sdi     (sdi),
    .data    (sh_data),
    .bit_cnt (bit_cnt),
    .full16  (full16),
    .over    (over)
  );

  assign wr_shift = ctr_is_shift(ctr_word) &&  ctr_word[CTR_MODE];
  assign rd_shift = ctr_is_shift(ctr_word) && !ctr_word[CTR_MODE];
  // Word as it will stand after this cycle's shift; compared on the bit-16 edge.
  assign rd_word  = {sh_data[WIDTH-2:0], sdi};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_clr    = 1'b0;
    sh_shift  = 1'b0;
    fe_set    = 1'b0;
    ue_set    = 1'b0;
    wr_accept = 1'b0;
    rd_done   = 1'b0;
    upd_start = 1'b0;
    upd_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        case (ctr_word)
          CTR_WR_ST: begin
            state_nxt = ST_WR;
            sh_clr    = 1'b1;
            sh_shift  = 1'b1;
          end
          CTR_RD_ST: begin
            state_nxt = ST_RD;
            sh_clr    = 1'b1;
            sh_shift  = 1'b1;
          end
          CTR_UPD: begin
            state_nxt = ST_UPD;
            upd_start = 1'b1;
          end
          CTR_IDLE: ;
          // Illegal patterns and shift cycles with no frame open.
          default: fe_set = 1'b1;
        endcase
      end
      ST_WR: begin
        if (ctr_word == CTR_IDLE) begin
          state_nxt = ST_IDLE;
          if (full16 && !over) begin
            wr_accept = 1'b1;
          end else begin
            fe_set = 1'b1;
          end
        end else if (wr_shift) begin
          if (full16) begin
            fe_set    = 1'b1;
            state_nxt = ST_ABORT;
          end else begin
            sh_shift = 1'b1;
          end
        end else begin
          fe_set    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (ctr_word == CTR_IDLE) begin
          state_nxt = ST_IDLE;
          if (!full16) begin
            fe_set = 1'b1;
          end
        end else if (rd_shift) begin
          if (full16) begin
            fe_set    = 1'b1;
            state_nxt = ST_ABORT;
          end else begin
            sh_shift = 1'b1;
            rd_done  = (bit_cnt == 5'(WIDTH - 1));
          end
        end else begin
          fe_set    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_UPD: begin
        if (ctr_word == CTR_UPD) begin
          upd_inc = 1'b1;
        end else if (ctr_word == CTR_IDLE) begin
          state_nxt = ST_IDLE;
          ue_set    = (int'(upd_cnt) < UPD_MIN);
        end else begin
          fe_set    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ABORT: begin
        // Swallow the rest of an overlong frame until the bus returns to idle.
        if (ctr_word == CTR_IDLE) begin
          state_nxt = ST_IDLE;
        end else if (!ctr_legal(ctr_word)) begin
          fe_set    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dac_code  <= '0;
      dac_out   <= '0;
      upd_pulse <= 1'b0;
      dac_err   <= 1'b0;
      rd_cnt    <= '0;
      frame_err <= 1'b0;
      upd_err   <= 1'b0;
      upd_cnt   <= '0;
    end else begin
      upd_pulse <= upd_start;
      if (wr_accept) begin
        dac_code <= sh_data;
        rd_cnt   <= '0;
        dac_err  <= 1'b0;
      end else if (rd_done) begin
        rd_cnt  <= rd_cnt + 3'd1;
        dac_err <= (rd_word != dac_code);
      end
      if (upd_start) begin
        dac_out <= dac_code;
        upd_cnt <= 3'd1;
      end else if (upd_inc) begin
        upd_cnt <= sat_inc3(upd_cnt);
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      if (fe_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
      if (ue_set) begin
        upd_err <= 1'b1;
      end else if (clr_err) begin
        upd_err <= 1'b0;
      end
    end
  end

endmodule
